async_transmitter: RTL and testbench
====================================

# async_transmitter

UART transmit serializer, the transmit-side counterpart of the codebase's oversampling UART receiver. It accepts a byte through a start/busy handshake and drives an 8N1 frame (optionally 8E1) LSB-first on a registered serial line. Bit timing comes from an internal integer baud divider, so no oversampling is used. It sits between user logic and the board TxD pin.

## Interface
- `ClkFrequency`, default 50000000: clock frequency in Hz.
- `Baud`, default 115200: line rate. The bit period is `D = ClkFrequency / Baud` (integer division, 434 by default). Legal range is `D >= 2`.
- `StopBits`, default 1: number of stop bits, either 1 or 2.
- `clk`  in  1: single clock. All logic is on its rising edge.
- `rst`  in  1: reset, **synchronous and active-high**.
- `TxD_start`  in  1: request to send `TxD_data`. It is sampled only in IDLE.
- `TxD_data`  in  8: byte to send. It is captured on the edge that accepts `TxD_start`.
- `TxD`  out  1: serial line, registered. Idle level is 1.
- `TxD_busy`  out  1: high from the accepting edge until the frame completes.
- `TxD_done`  out  1: one-cycle pulse on the edge that returns the block to IDLE.

## Operation
- Reset values: `TxD=1`, `TxD_busy=0`, `TxD_done=0`, state IDLE, shift register 0, bit counter 0, divider 0.
- States and their `TxD` level:
  - IDLE: `TxD=1`.
  - START: `TxD=0`.
  - DATA: `TxD=shift[0]`.
  - PARITY (macro only): `TxD` = parity bit.
  - STOP: `TxD=1`.
  - STOP2 (`StopBits=2` only): `TxD=1`.
- IDLE with `TxD_start=1`:
  - Go to START.
  - Load the shift register from `TxD_data` and latch the parity bit.
  - Clear the divider.
  - Set `TxD_busy=1` and `TxD=0` on the same edge.
- Divider behaviour:
  - Counts 0..D-1 while not IDLE.
  - `tick` is asserted when the count equals D-1. The count then wraps to 0.
  - The divider is held at 0 in IDLE.
- Transitions, taken only on `tick`:
  - START → DATA, with the bit counter at 0.
  - DATA: shift the register right and increment the counter. After bit 7 go to PARITY if the macro is defined, otherwise STOP.
  - PARITY → STOP.
  - STOP → STOP2 if `StopBits=2`, otherwise IDLE.
  - STOP2 → IDLE.
- Entering IDLE: `TxD_busy←0` and `TxD_done←1` for exactly one cycle.
- `TxD_start` outside IDLE is ignored and never queued. Changes to `TxD_data` during a frame have no effect.
- Simultaneous `rst` and `TxD_start`: reset wins and nothing is transmitted.
- Reset mid-frame: on the next edge `TxD=1` and `TxD_busy=0`. No `TxD_done` pulse is produced and the partial frame is abandoned.

## Timing
- Acceptance latency: `TxD` falls on the accepting edge itself, so it is visible one cycle after `TxD_start` is sampled.
- Every bit, including start, parity and stop bits, lasts exactly D cycles.
- Frame length `F = D·(10 + P + StopBits − 1)`, where P=1 if the macro is defined and 0 otherwise. `TxD_busy` is high for exactly F cycles.
- Back-to-back frames:
  - The block is IDLE in the cycle `TxD_done` is high.
  - A `TxD_start` held high in that cycle is accepted on the next edge.
  - The resulting minimum gap between frames is 1 cycle of `TxD=1`.
- `TxD` comes from a flop with no combinational path from any input.

## Configuration
- `ASYNC_TX_PARITY_EN` defined:
  - PARITY state is compiled in.
  - The parity bit is `^TxD_data` (even parity), inserted between D7 and the stop bit.
  - F grows by D.
- Not defined:
  - No PARITY state and no parity flop.
  - The frame is 8N1 (8N2 with `StopBits=2`).

## Structure
- Shared package/include `uart_pkg` holds:
  - State encodings: `IDLE`, `START`, `DATA`, `PARITY`, `STOP`, `STOP2`, 3 bits wide.
  - `DATA_BITS=8`.
  - Idle line level constant.
- These are reused by the receiver-side FSMs.
- Sub-module `tx_baud_div`:
  - Parameters `ClkFrequency`, `Baud`.
  - Ports `clk`, `rst`, `en`, `tick`.
  - Counter cleared when `en=0`.
- Everything else (FSM, shift register, bit counter, outputs) lives in `async_transmitter`.

## Test plan
All scenarios use `ClkFrequency=1600`, `Baud=100`, so D=16.
- **Reset:**
  - Stimulus: hold `rst` 3 cycles with `TxD_start=1`.
  - Required: `TxD=1`, `busy=0`, `done=0` throughout; no start bit after release until a new request.
- **Byte 0xA5, no macro:**
  - Stimulus: pulse `TxD_start` for 1 cycle.
  - Required: `TxD` sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles.
  - Required: `busy` high for 160 cycles, then a 1-cycle `done`.
- **Parity, macro defined:**
  - Stimulus: send 0x07.
  - Required: parity bit = 1, frame 176 cycles.
  - Stimulus: send 0x03.
  - Required: parity bit = 0.
- **Back-to-back with `StopBits=2`:**
  - Stimulus: hold `TxD_start=1` with 0x00 then 0xFF.
  - Required: two frames of 176 cycles each, separated by exactly 1 idle cycle.
  - Required: a second start arriving mid-frame is ignored.
- **Reset mid-frame:**
  - Stimulus: assert `rst` during DATA bit 4 of 0x55.
  - Required: next edge `TxD=1`, `busy=0`, no `done`.
  - Required: a subsequent 0x55 is sent complete and correct.
- **Data change mid-frame:**
  - Stimulus: start 0x3C, then change `TxD_data` to 0xFF after 20 cycles.
  - Required: 0x3C is transmitted unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, data width and idle line level.
// Used by async_transmitter (build macro ASYNC_TX_PARITY_EN) and the receiver FSMs.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        STOP2  = 3'd5
    } uart_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/async_transmitter_if.sv
// Byte handshake and serial-line bundle between user logic and async_transmitter.
interface async_transmitter_if;

    logic       TxD_start;
    logic [7:0] TxD_data;
    logic       TxD;
    logic       TxD_busy;
    logic       TxD_done;

    modport master (
        output TxD_start,
        output TxD_data,
        input  TxD,
        input  TxD_busy,
        input  TxD_done
    );

    modport slave (
        input  TxD_start,
        input  TxD_data,
        output TxD,
        output TxD_busy,
        output TxD_done
    );

endinterface

// File: rtl/tx_baud_div.sv
// Integer baud divider: tick once every ClkFrequency/Baud cycles while enabled.
module tx_baud_div #(
    parameter int ClkFrequency = 50000000,
    parameter int Baud         = 115200
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int D = ClkFrequency / Baud;
    localparam int W = (D > 1) ? $clog2(D) : 1;
    localparam logic [W-1:0] LAST = W'(D - 1);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

    assign tick = en && (cnt_reg == LAST);

endmodule

// File: rtl/async_transmitter.sv
// UART 8N1/8N2 serializer with registered TxD; define ASYNC_TX_PARITY_EN
// to insert an even-parity bit after D7 (8E1/8E2).
module async_transmitter
    import uart_pkg::*;
#(
    parameter int ClkFrequency = 50000000,
    parameter int Baud         = 115200,
    parameter int StopBits     = 1
) (
    input  logic clk,
    input  logic rst,
    async_transmitter_if.slave tx
);

    localparam int CNT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    uart_state_t          state_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic [CNT_W-1:0]     bit_cnt_reg;
    logic                 txd_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic                 tick;
`ifdef ASYNC_TX_PARITY_EN
    logic                 parity_reg;
`endif

    tx_baud_div #(
        .ClkFrequency (ClkFrequency),
        .Baud         (Baud)
    ) u_baud_div (
        .clk  (clk),
        .rst  (rst),
        .en   (state_reg != IDLE),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            txd_reg     <= IDLE_LEVEL;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
`ifdef ASYNC_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (tx.TxD_start) begin
                        state_reg   <= START;
                        shift_reg   <= tx.TxD_data;
                        bit_cnt_reg <= '0;
                        txd_reg     <= 1'b0;
                        busy_reg    <= 1'b1;
`ifdef ASYNC_TX_PARITY_EN
                        parity_reg  <= ^tx.TxD_data;
`endif
                    end
                end
                START: begin
                    if (tick) begin
                        state_reg   <= DATA;
                        bit_cnt_reg <= '0;
                        txd_reg     <= shift_reg[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_reg   <= shift_reg >> 1;
                        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                        if (bit_cnt_reg == LAST_BIT) begin
`ifdef ASYNC_TX_PARITY_EN
                            state_reg <= PARITY;
                            txd_reg   <= parity_reg;
`else
                            state_reg <= STOP;
                            txd_reg   <= IDLE_LEVEL;
`endif
                        end else begin
                            // shift_reg[1] becomes the new LSB on this edge
                            txd_reg <= shift_reg[1];
                        end
                    end
                end
`ifdef ASYNC_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state_reg <= STOP;
                        txd_reg   <= IDLE_LEVEL;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (StopBits == 2) begin
                            state_reg <= STOP2;
                        end else begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                        txd_reg <= IDLE_LEVEL;
                    end
                end
                STOP2: begin
                    if (tick) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        txd_reg   <= IDLE_LEVEL;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    txd_reg   <= IDLE_LEVEL;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign tx.TxD      = txd_reg;
    assign tx.TxD_busy = busy_reg;
    assign tx.TxD_done = done_reg;

endmodule

// File: tb/tb_async_transmitter.sv
// Bench for async_transmitter: one instance with 1 stop bit, one with 2, both D=16;
// expected line levels come from a bit-list frame model (parity when ASYNC_TX_PARITY_EN).
module tb_async_transmitter;

    localparam int CLK_F = 1600;
    localparam int BAUD  = 100;
    localparam int D     = CLK_F / BAUD;
`ifdef ASYNC_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    async_transmitter_if ifa ();
    async_transmitter_if ifb ();

    async_transmitter #(.ClkFrequency(CLK_F), .Baud(BAUD), .StopBits(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .tx  (ifa)
    );

    async_transmitter #(.ClkFrequency(CLK_F), .Baud(BAUD), .StopBits(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .tx  (ifb)
    );

    int checks   = 0;
    int failures = 0;

    task automatic expect3(input string tag, input logic [2:0] o, input logic [2:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed{txd,busy,done}=%b expected=%b", tag, o, e);
        end
    endtask

    function automatic logic [2:0] obs(input int s);
        if (s != 0) return {ifb.TxD, ifb.TxD_busy, ifb.TxD_done};
        return {ifa.TxD, ifa.TxD_busy, ifa.TxD_done};
    endfunction

    task automatic set_start(input int s, input logic v);
        if (s != 0) ifb.TxD_start = v;
        else        ifa.TxD_start = v;
    endtask

    task automatic set_data(input int s, input logic [7:0] d);
        if (s != 0) ifb.TxD_data = d;
        else        ifa.TxD_data = d;
    endtask

    task automatic idle_check(input int s, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            expect3($sformatf("idle%0d_c%0d", s, k), obs(s), 3'b100);
        end
    endtask

    // Called at the negedge right after TxD_start was raised: checks every cycle of
    // the frame, optional mid-frame poke of start/data, then the done cycle or an abort.
    task automatic check_frame(input int s, input logic [7:0] d, input bit keep,
                               input int poke_at, input logic poke_start,
                               input logic [7:0] poke_data, input int abort_at,
                               input logic done_start, input logic [7:0] done_data);
        logic bits[$];
        int   f;
        int   last;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (P == 1) bits.push_back(($countones(d) % 2) == 1);
        for (int i = 0; i < ((s != 0) ? 2 : 1); i++) bits.push_back(1'b1);
        f    = bits.size() * D;
        last = (abort_at >= 0) ? abort_at : f - 1;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            expect3($sformatf("frame%0d_%02h_c%0d", s, d, k), obs(s), {bits[k / D], 2'b10});
            if (k == 0 && !keep) set_start(s, 1'b0);
            if (k == poke_at) begin
                set_start(s, poke_start);
                set_data(s, poke_data);
            end
            if (poke_at >= 0 && k == poke_at + 1) set_start(s, keep);
        end
        if (abort_at >= 0) begin
            rst = 1'b1;
            @(negedge clk);
            expect3($sformatf("abort%0d_%02h", s, d), obs(s), 3'b100);
            rst = 1'b0;
        end else begin
            @(negedge clk);
            expect3($sformatf("done%0d_%02h", s, d), obs(s), 3'b101);
            set_start(s, done_start);
            set_data(s, done_data);
        end
    endtask

    initial begin
        logic [7:0] rd;
        int         rs;
        // reset held with a pending request on both instances
        rst = 1'b1;
        set_start(0, 1'b1); set_data(0, 8'hA5);
        set_start(1, 1'b1); set_data(1, 8'hA5);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            expect3($sformatf("rst_a_c%0d", k), obs(0), 3'b100);
            expect3($sformatf("rst_b_c%0d", k), obs(1), 3'b100);
        end
        rst = 1'b0;
        set_start(0, 1'b0);
        set_start(1, 1'b0);
        idle_check(0, 20);
        idle_check(1, 4);

        // 0xA5 with a stray mid-frame request that must not queue
        set_data(0, 8'hA5); set_start(0, 1'b1);
        check_frame(0, 8'hA5, 1'b0, 40, 1'b1, 8'h12, -1, 1'b0, 8'h00);
        idle_check(0, 40);

        // parity patterns
        set_data(0, 8'h07); set_start(0, 1'b1);
        check_frame(0, 8'h07, 1'b0, -1, 1'b0, 8'h00, -1, 1'b0, 8'h00);
        idle_check(0, 3);
        set_data(0, 8'h03); set_start(0, 1'b1);
        check_frame(0, 8'h03, 1'b0, -1, 1'b0, 8'h00, -1, 1'b0, 8'h00);
        idle_check(0, 3);

        // back-to-back on the two-stop-bit instance, start held high throughout
        set_data(1, 8'h00); set_start(1, 1'b1);
        check_frame(1, 8'h00, 1'b1, -1, 1'b0, 8'h00, -1, 1'b1, 8'hFF);
        check_frame(1, 8'hFF, 1'b0, -1, 1'b0, 8'h00, -1, 1'b0, 8'h00);
        idle_check(1, 20);

        // reset during data bit 4 of 0x55, then a clean resend
        set_data(0, 8'h55); set_start(0, 1'b1);
        check_frame(0, 8'h55, 1'b0, -1, 1'b0, 8'h00, 5 * D + 5, 1'b0, 8'h00);
        idle_check(0, 10);
        set_data(0, 8'h55); set_start(0, 1'b1);
        check_frame(0, 8'h55, 1'b0, -1, 1'b0, 8'h00, -1, 1'b0, 8'h00);
        idle_check(0, 2);

        // data changes after 20 cycles must not affect the frame
        set_data(0, 8'h3C); set_start(0, 1'b1);
        check_frame(0, 8'h3C, 1'b0, 19, 1'b0, 8'hFF, -1, 1'b0, 8'h00);
        idle_check(0, 2);

        // randomized bytes, instances and mid-frame data changes
        for (int r = 0; r < 8; r++) begin
            rs = int'($urandom_range(0, 1));
            rd = 8'($urandom);
            idle_check(rs, int'($urandom_range(1, 6)));
            set_data(rs, rd); set_start(rs, 1'b1);
            check_frame(rs, rd, 1'b0, int'($urandom_range(1, 150)), 1'b0, 8'($urandom),
                        -1, 1'b0, 8'h00);
        end
        idle_check(0, 4);
        idle_check(1, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
